down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 147 ++++++++++++++
 tb/tb_down_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable N-bit down counter with IDLE/RUN/EXPIRED control FSM and cascade borrow.
// Latency: load takes effect on the next clk edge; done is registered one cycle after underflow; bout is combinational.
// Backpressure: none. enable stalls the count, and a higher cascade stage is stalled by holding its enable (a lower bout) low.
//
// Ports:
//   clk    - single clock; all state updates on its rising edge
//   reset  - asynchronous, active-high; clears count, done and state immediately
//   enable - count enable; also the cascade input fed by a lower stage's bout
//   load   - synchronous load/re-arm strobe; wins over enable
//   din    - load value (N bits)
//   qout   - current count (N bits)
//   bout   - borrow out = busy & enable & (qout == 0); the enable for the next stage up
//   busy   - high while in RUN
//   done   - one-cycle pulse in the cycle after an underflow edge
//
// Build option: define DOWN_COUNTER_RELOAD_EN for periodic operation. On underflow the
// counter reloads the last loaded value and stays in RUN, so the period is
// reload_reg+1 enabled cycles. Without it the counter is one-shot. It holds 0 and
// parks in EXPIRED until the next load, and no reload register is built.

module down_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic [N-1:0] qout,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO = '0;

  state_t       state, state_n;
  logic [N-1:0] count, count_n;
  logic         done_r, done_n;
  logic         at_zero;
  logic         underflow;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [N-1:0] reload_reg, reload_n;
`endif

  assign at_zero = (count == ZERO);

  // Underflow is the enabled edge that would take the count below zero.
  // load suppresses it because a reload on the same edge replaces the count.
  assign underflow = (state == RUN) & enable & ~load & at_zero;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= ZERO;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      done_r <= done_n;
    end
  end

`ifdef DOWN_COUNTER_RELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_reg <= ZERO;
    end else begin
      reload_reg <= reload_n;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-count logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    count_n  = count;
    done_n   = underflow;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_n = reload_reg;
`endif

    if (load) begin
      // Load re-arms from any state, including a mid-count RUN.
      state_n  = RUN;
      count_n  = din;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_n = din;
`endif
    end else begin
      unique case (state)
        RUN: begin
          if (enable) begin
            if (!at_zero) begin
              count_n = count - ONE;
            end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
              // Periodic mode: go straight back to the reload value and keep running.
              count_n = reload_reg;
              state_n = RUN;
`else
              // One-shot mode: park at zero until the next load.
              count_n = ZERO;
              state_n = EXPIRED;
`endif
            end
          end
        end
        IDLE, EXPIRED: begin
          // The count is frozen outside RUN, whatever enable does.
          count_n = count;
          state_n = state;
        end
        default: begin
          // Unreachable encoding: fall back to a safe, stopped state.
          count_n = ZERO;
          state_n = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign qout = count;
  assign busy = (state == RUN);
  assign done = done_r;

  // The borrow is deliberately not gated by load. A higher stage sees the same
  // borrow whether or not this stage is being re-armed on that edge.
  assign bout = busy & enable & at_zero;

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  localparam int N = 4;

`ifdef DOWN_COUNTER_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         load;
  logic [N-1:0] din;
  logic [N-1:0] qout;
  logic         bout;
  logic         busy;
  logic         done;

  // cascade pair
  logic         c_en;
  logic         c_load;
  logic [N-1:0] lo_din;
  logic [N-1:0] hi_din;
  logic [N-1:0] lo_q;
  logic [N-1:0] hi_q;
  logic         lo_bout;
  logic         hi_bout;
  logic         lo_busy;
  logic         hi_busy;
  logic         lo_done;
  logic         hi_done;

  always #5 clk = ~clk;

  down_counter #(.N(N)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .din(din),
    .qout(qout), .bout(bout), .busy(busy), .done(done)
  );

  down_counter #(.N(N)) lo (
    .clk(clk), .reset(reset), .enable(c_en), .load(c_load), .din(lo_din),
    .qout(lo_q), .bout(lo_bout), .busy(lo_busy), .done(lo_done)
  );

  down_counter #(.N(N)) hi (
    .clk(clk), .reset(reset), .enable(lo_bout), .load(c_load), .din(hi_din),
    .qout(hi_q), .bout(hi_bout), .busy(hi_busy), .done(hi_done)
  );

  typedef struct packed {
    logic [N-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One clock cycle. The inputs are driven 1 time unit after an edge. bout is
  // checked before the next edge. The post-edge expectation is queued now and
  // popped and compared 1 time unit after the edge.
  task automatic cyc(input string tag, input logic en, input logic ld, input logic [N-1:0] d,
                     input logic eb, input logic [N-1:0] eq, input logic ebusy, input logic edone);
    exp_t e;
    enable = en;
    load   = ld;
    din    = d;
    #1;
    chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
    sb.push_back(exp_t'{q: eq, busy: ebusy, done: edone});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".qout"}, {28'd0, qout}, {28'd0, e.q});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, e.done});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    load   = 1'b0;
    din    = '0;
    c_en   = 1'b0;
    c_load = 1'b0;
    lo_din = 4'd0;
    hi_din = 4'd1;

    // Reset values, with enable high during reset
    #2;
    chk("rst.qout", {28'd0, qout}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.bout", {31'd0, bout}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // After reset the counter stays idle until it is loaded
    cyc("idle1", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc("idle2", 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);

    // Load 3 and count 3,2,1,0, then underflow
    cyc("ld3",  1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0);
    cyc("c2",   1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    cyc("c1",   1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    cyc("c0",   1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc("uf",   1'b1, 1'b0, 4'd0, 1'b1, RL ? 4'd3 : 4'd0, RL, 1'b1);
    cyc("post", 1'b1, 1'b0, 4'd0, 1'b0, RL ? 4'd2 : 4'd0, RL, 1'b0);
    cyc("hold", 1'b1, 1'b0, 4'd0, 1'b0, RL ? 4'd1 : 4'd0, RL, 1'b0);

    // load beats enable at qout=1
    cyc("ld2",    1'b0, 1'b1, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0);
    cyc("dec1",   1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    cyc("ldpri",  1'b1, 1'b1, 4'd9, 1'b0, 4'd9, 1'b1, 1'b0);
    cyc("nodone", 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);

    // enable pattern 1,0,1 starting from 5
    cyc("ld5", 1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0);
    cyc("en1", 1'b1, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    cyc("en0", 1'b0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    cyc("en1b",1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);

    // bout is not gated by load; loading 0 underflows on the next enabled edge
    cyc("ld0",     1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc("bout_ld", 1'b1, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0);
    cyc("ld0b",    1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc("uf0",     1'b1, 1'b0, 4'd0, 1'b1, 4'd0, RL, 1'b1);
    cyc("uf0post", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, RL, 1'b0);

    // Asynchronous reset at qout=6 in RUN
    cyc("ld7", 1'b0, 1'b1, 4'd7, 1'b0, 4'd7, 1'b1, 1'b0);
    cyc("q6",  1'b1, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    enable = 1'b1;
    load   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.qout", {28'd0, qout}, 32'd0);
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.done", {31'd0, done}, 32'd0);
    chk("arst.bout", {31'd0, bout}, 32'd0);
    #1;
    reset = 1'b0;
    cyc("postrst1", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc("postrst2", 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Reset while done is high clears it immediately
    cyc("ld0c", 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc("ufc",  1'b1, 1'b0, 4'd0, 1'b1, 4'd0, RL, 1'b1);
    enable = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("arst2.done", {31'd0, done}, 32'd0);
    chk("arst2.busy", {31'd0, busy}, 32'd0);
    #1;
    reset = 1'b0;
    cyc("afterrst", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Cascade: upper loaded 1, lower loaded 0
    c_en   = 1'b0;
    c_load = 1'b1;
    @(posedge clk);
    #1;
    c_load = 1'b0;
    chk("cas.load.cnt",  {24'd0, hi_q, lo_q}, 32'h10);
    chk("cas.load.busy", {30'd0, hi_busy, lo_busy}, 32'h3);
    c_en = 1'b1;
    #1;
    chk("cas.lo_bout", {31'd0, lo_bout}, 32'd1);
    chk("cas.hi_bout", {31'd0, hi_bout}, 32'd0);
    @(posedge clk);
    #1;
    chk("cas.e1.cnt",  {24'd0, hi_q, lo_q}, 32'h00);
    chk("cas.e1.done", {30'd0, hi_done, lo_done}, 32'h1);
    chk("cas.e1.busy", {30'd0, hi_busy, lo_busy}, {30'd0, 1'b1, RL});
    @(posedge clk);
    #1;
    chk("cas.e2.cnt",  {24'd0, hi_q, lo_q}, RL ? 32'h10 : 32'h00);
    chk("cas.e2.done", {30'd0, hi_done, lo_done}, {30'd0, RL, RL});
    chk("cas.e2.busy", {31'd0, hi_busy}, 32'd1);
    c_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
